// File: rtl/mipi_tx_pkg.sv
// Shared types and constants for the MIPI TX video packet scheduler.
// Data types, widths, FSM states and the RGB888 word-count helper.
package mipi_tx_pkg;

    localparam int DT_W   = 6;
    localparam int WC_W   = 16;
    localparam int LINE_W = 12;

    localparam logic [DT_W-1:0] DT_VSS    = 6'h01;
    localparam logic [DT_W-1:0] DT_VSE    = 6'h11;
    localparam logic [DT_W-1:0] DT_HSS    = 6'h21;
    localparam logic [DT_W-1:0] DT_HSE    = 6'h31;
    localparam logic [DT_W-1:0] DT_RGB888 = 6'h3E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HSE,
        ST_PIX_WAIT,
        ST_PIX_REQ,
        ST_PIX_PAYLOAD,
        ST_LINE_WAIT
    } state_e;

    function automatic logic [WC_W-1:0] rgb888_wc(input int h_active);
        int bytes;
        bytes = h_active * 3;
        return bytes[WC_W-1:0];
    endfunction

endpackage

// File: rtl/mipi_tx_line_timer.sv
// Line period counter with wrap pulse, line index and frame-end flag.
// The index moves only on explicit advance/restart from the scheduler.
module mipi_tx_line_timer
    import mipi_tx_pkg::*;
#(
    parameter int LINE_CYCLES = 2200,
    parameter int FRAME_LINES = 1938
) (
    input  logic              CLK_tx,
    input  logic              RST,
    input  logic              run,
    input  logic              restart,
    input  logic              advance,
    output logic [LINE_W-1:0] line_index,
    output logic              wrap,
    output logic              frame_end
);

    localparam int TW = $clog2(LINE_CYCLES);

    logic [TW-1:0] cnt;

    assign wrap      = run && (cnt == TW'(LINE_CYCLES - 1));
    assign frame_end = (line_index == LINE_W'(FRAME_LINES - 1));

    always_ff @(posedge CLK_tx) begin
        if (RST) begin
            cnt <= '0;
        end else if (!run || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK_tx) begin
        if (RST) begin
            line_index <= '0;
        end else if (restart) begin
            line_index <= '0;
        end else if (advance) begin
            line_index <= line_index + 1'b1;
        end
    end

endmodule

// File: rtl/mipi_tx_video_pkt_sched.sv
// Video-mode packet scheduler: sync short packets and one RGB888 long packet per line.
// MIPI_TX_SYNC_PULSE_EN selects sync-pulse mode (HSE after each sync start, VSE line).
module mipi_tx_video_pkt_sched
    import mipi_tx_pkg::*;
#(
    parameter int H_ACTIVE    = 1080,
    parameter int V_ACTIVE    = 1920,
    parameter int VSA_LINES   = 2,
    parameter int VBP_LINES   = 8,
    parameter int VFP_LINES   = 8,
    parameter int LINE_CYCLES = 2200
) (
    input  logic              CLK_tx,
    input  logic              RST,
    input  logic              Enable,
    input  logic              Fifo_line_ready,
    input  logic              Tx_cmd_ack,
    input  logic              Tx_payload_en_last,
    output logic              Tx_cmd_req,
    output logic [DT_W-1:0]   Tx_cmd_data_type,
    output logic [WC_W-1:0]   Tx_cmd_word_count,
    output logic [LINE_W-1:0] Line_index,
    output logic              Frame_start,
    output logic              Line_overrun
);

    localparam int FRAME_LINES = VSA_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
    localparam int ACT_FIRST   = VSA_LINES + VBP_LINES;
    localparam int ACT_LAST    = ACT_FIRST + V_ACTIVE - 1;

    localparam logic [WC_W-1:0] PIX_WC = rgb888_wc(H_ACTIVE);

    state_e state_q, state_d;
    logic   req_q, req_d;
    logic   fs_q, fs_d;
    logic   ovr_q;
    logic   pend_q, pend_d;

    logic run, restart, advance;
    logic wrap, frame_end;
    logic busy, pend, ack_ok;
    logic line_active;
    logic after_sync, line_done;
    logic [DT_W-1:0] sync_dt;

    mipi_tx_line_timer #(
        .LINE_CYCLES (LINE_CYCLES),
        .FRAME_LINES (FRAME_LINES)
    ) u_timer (
        .CLK_tx     (CLK_tx),
        .RST        (RST),
        .run        (run),
        .restart    (restart),
        .advance    (advance),
        .line_index (Line_index),
        .wrap       (wrap),
        .frame_end  (frame_end)
    );

    assign run    = (state_q != ST_IDLE);
    assign ack_ok = Tx_cmd_ack && req_q;
    assign busy   = state_q inside {ST_SYNC, ST_HSE, ST_PIX_WAIT,
                                    ST_PIX_REQ, ST_PIX_PAYLOAD};
    assign pend   = pend_q || (wrap && busy);

    assign line_active = (Line_index >= LINE_W'(ACT_FIRST)) &&
                         (Line_index <= LINE_W'(ACT_LAST));

    always_comb begin
        sync_dt = DT_HSS;
        if (Line_index == '0) begin
            sync_dt = DT_VSS;
`ifdef MIPI_TX_SYNC_PULSE_EN
        end else if (Line_index == LINE_W'(VSA_LINES)) begin
            sync_dt = DT_VSE;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        fs_d       = 1'b0;
        pend_d     = pend;
        restart    = 1'b0;
        advance    = 1'b0;
        after_sync = 1'b0;
        line_done  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (Enable) begin
                    state_d = ST_SYNC;
                    restart = 1'b1;
                    fs_d    = 1'b1;
                end
            end
            ST_SYNC: begin
                if (ack_ok) begin
`ifdef MIPI_TX_SYNC_PULSE_EN
                    state_d = ST_HSE;
`else
                    after_sync = 1'b1;
`endif
                end
            end
            ST_HSE: begin
                if (ack_ok) begin
                    after_sync = 1'b1;
                end
            end
            ST_PIX_WAIT: begin
                // an overrun here abandons the line: no packet is in flight
                if (pend) begin
                    line_done = 1'b1;
                end else if (Fifo_line_ready) begin
                    state_d = ST_PIX_REQ;
                end
            end
            ST_PIX_REQ: begin
                if (ack_ok) begin
                    state_d = ST_PIX_PAYLOAD;
                end
            end
            ST_PIX_PAYLOAD: begin
                if (Tx_payload_en_last) begin
                    if (pend) begin
                        line_done = 1'b1;
                    end else begin
                        state_d = ST_LINE_WAIT;
                    end
                end
            end
            ST_LINE_WAIT: begin
                if (wrap) begin
                    line_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (after_sync) begin
            if (pend) begin
                line_done = 1'b1;
            end else if (line_active) begin
                state_d = ST_PIX_WAIT;
            end else begin
                state_d = ST_LINE_WAIT;
            end
        end

        if (line_done) begin
            pend_d = 1'b0;
            if (frame_end) begin
                restart = 1'b1;
                if (Enable) begin
                    state_d = ST_SYNC;
                    fs_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                advance = 1'b1;
                state_d = ST_SYNC;
            end
        end
    end

    // an accepted request always drops for at least one cycle
    assign req_d = (state_d inside {ST_SYNC, ST_HSE, ST_PIX_REQ}) && !ack_ok;

    always_ff @(posedge CLK_tx) begin
        if (RST) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            fs_q    <= fs_d;
            ovr_q   <= ovr_q || (wrap && busy);
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        Tx_cmd_data_type  = '0;
        Tx_cmd_word_count = '0;
        if (req_q) begin
            unique case (state_q)
                ST_SYNC:    Tx_cmd_data_type = sync_dt;
                ST_HSE:     Tx_cmd_data_type = DT_HSE;
                ST_PIX_REQ: begin
                    Tx_cmd_data_type  = DT_RGB888;
                    Tx_cmd_word_count = PIX_WC;
                end
                default: ;
            endcase
        end
    end

    assign Tx_cmd_req   = req_q;
    assign Frame_start  = fs_q;
    assign Line_overrun = ovr_q;

endmodule

// File: tb/tb_mipi_tx_video_pkt_sched.sv
// Bench for mipi_tx_video_pkt_sched: per-frame packet tables plus corner sequences.
// Build with MIPI_TX_SYNC_PULSE_EN defined to check sync-pulse ordering.
module tb_mipi_tx_video_pkt_sched;

    typedef struct {
        int          line;
        logic [5:0]  dt;
        logic [15:0] wc;
        int          rise;
        int          ack_dly;
        int          hold;
        int          en_dly;
        bit          chk_ovr;
        bit          rst_pay;
    } vec_t;

    logic        CLK_tx = 1'b0;
    logic        RST;
    logic        Enable;
    logic        Fifo_line_ready;
    logic        Tx_cmd_ack;
    logic        Tx_payload_en_last;
    logic        Tx_cmd_req;
    logic [5:0]  Tx_cmd_data_type;
    logic [15:0] Tx_cmd_word_count;
    logic [11:0] Line_index;
    logic        Frame_start;
    logic        Line_overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int f0     = 0;
    int fs_cnt = 0;
    int fa     = 0;

    vec_t tbl[$];
    vec_t sb[$];

    mipi_tx_video_pkt_sched #(
        .H_ACTIVE    (4),
        .V_ACTIVE    (3),
        .VSA_LINES   (1),
        .VBP_LINES   (1),
        .VFP_LINES   (1),
        .LINE_CYCLES (40)
    ) dut (
        .CLK_tx             (CLK_tx),
        .RST                (RST),
        .Enable             (Enable),
        .Fifo_line_ready    (Fifo_line_ready),
        .Tx_cmd_ack         (Tx_cmd_ack),
        .Tx_payload_en_last (Tx_payload_en_last),
        .Tx_cmd_req         (Tx_cmd_req),
        .Tx_cmd_data_type   (Tx_cmd_data_type),
        .Tx_cmd_word_count  (Tx_cmd_word_count),
        .Line_index         (Line_index),
        .Frame_start        (Frame_start),
        .Line_overrun       (Line_overrun)
    );

    always #5 CLK_tx = ~CLK_tx;

    always @(posedge CLK_tx) cyc <= cyc + 1;

    always @(posedge CLK_tx) begin
        #1;
        if (Frame_start === 1'b1) begin
            f0 = cyc;
            fs_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK_tx);
        #2;
    endtask

    // scoreboard: entries pushed when ack is driven, popped at the handshake
    always @(negedge CLK_tx) begin
        if (Tx_cmd_req === 1'b1 && Tx_cmd_ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("pkt_dt", int'(Tx_cmd_data_type), int'(e.dt));
                chk("pkt_wc", int'(Tx_cmd_word_count), int'(e.wc));
                chk("pkt_line", int'(Line_index), e.line);
            end
        end
    end

    function automatic vec_t mk(input int line, input logic [5:0] dt,
                                input logic [15:0] wc, input int rise,
                                input int en_dly);
        vec_t v;
        v.line    = line;
        v.dt      = dt;
        v.wc      = wc;
        v.rise    = rise;
        v.ack_dly = 1;
        v.hold    = 0;
        v.en_dly  = en_dly;
        v.chk_ovr = 1'b0;
        v.rst_pay = 1'b0;
        return v;
    endfunction

    task automatic build_table();
        logic [5:0] s;
        tbl.delete();
        for (int l = 0; l < 6; l++) begin
            s = (l == 0) ? 6'h01 : 6'h21;
`ifdef MIPI_TX_SYNC_PULSE_EN
            if (l == 1) s = 6'h11;
`endif
            tbl.push_back(mk(l, s, 16'd0, 40 * l, 0));
`ifdef MIPI_TX_SYNC_PULSE_EN
            tbl.push_back(mk(l, 6'h31, 16'd0, -1, 0));
`endif
            if (l >= 2 && l <= 4)
                tbl.push_back(mk(l, 6'h3E, 16'd12, -1, 5));
        end
    endtask

    function automatic int idx_of(input int line, input logic [5:0] dt);
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].line == line && tbl[i].dt == dt) return i;
        return 0;
    endfunction

    task automatic run_frame(input bit drop_en);
        vec_t v;
        bit   found;
        bit   bad;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            found = 1'b0;
            for (int k = 0; k < 300; k++) begin
                if (Tx_cmd_req === 1'b1) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            if (!found) begin
                chk("req_timeout", 0, 1);
                return;
            end
            if (drop_en && i == 0) Enable = 1'b0;
            if (v.rise >= 0) chk("sync_rise_cycle", cyc - f0, v.rise);
            if (v.ack_dly > 0) repeat (v.ack_dly) tick();
            if (v.hold > 0) Fifo_line_ready = 1'b0;
            sb.push_back(v);
            Tx_cmd_ack = 1'b1;
            tick();
            Tx_cmd_ack = 1'b0;
            chk("req_drop_after_ack", int'(Tx_cmd_req), 0);
            if (v.hold > 0) begin
                bad = 1'b0;
                repeat (v.hold) begin
                    if (Tx_cmd_req !== 1'b0) bad = 1'b1;
                    tick();
                end
                if (Tx_cmd_req !== 1'b0) bad = 1'b1;
                chk("fifo_hold_req_low", int'(bad), 0);
                Fifo_line_ready = 1'b1;
                tick();
                chk("pix_req_after_ready", int'(Tx_cmd_req), 1);
            end
            if (v.dt == 6'h3E) begin
                if (v.rst_pay) begin
                    tick();
                    tick();
                    RST = 1'b1;
                    tick();
                    chk("rst_req", int'(Tx_cmd_req), 0);
                    chk("rst_dt", int'(Tx_cmd_data_type), 0);
                    chk("rst_wc", int'(Tx_cmd_word_count), 0);
                    chk("rst_line", int'(Line_index), 0);
                    chk("rst_fs", int'(Frame_start), 0);
                    chk("rst_ovr", int'(Line_overrun), 0);
                    RST = 1'b0;
                    tick();
                    chk("restart_fs", int'(Frame_start), 1);
                    chk("restart_req", int'(Tx_cmd_req), 1);
                    chk("restart_dt", int'(Tx_cmd_data_type), 'h01);
                    chk("restart_line", int'(Line_index), 0);
                    return;
                end
                repeat (v.en_dly) begin
                    if (v.chk_ovr && cyc - f0 == 119)
                        chk("ovr_before_wrap", int'(Line_overrun), 0);
                    if (v.chk_ovr && cyc - f0 == 120)
                        chk("ovr_at_wrap", int'(Line_overrun), 1);
                    tick();
                end
                Tx_payload_en_last = 1'b1;
                tick();
                Tx_payload_en_last = 1'b0;
                if (v.chk_ovr) begin
                    chk("hss_after_last_req", int'(Tx_cmd_req), 1);
                    chk("hss_after_last_dt", int'(Tx_cmd_data_type), 'h21);
                    chk("hss_after_last_line", int'(Line_index), v.line + 1);
                end
            end
        end
    endtask

    task automatic settle();
        for (int k = 0; k < 400 && (cyc - f0) < 250; k++) tick();
    endtask

    initial begin
        vec_t t;
        int   j;
        RST                = 1'b1;
        Enable             = 1'b1;
        Fifo_line_ready    = 1'b1;
        Tx_cmd_ack         = 1'b0;
        Tx_payload_en_last = 1'b0;
        repeat (3) tick();
        chk("reset_req", int'(Tx_cmd_req), 0);
        chk("reset_dt", int'(Tx_cmd_data_type), 0);
        chk("reset_wc", int'(Tx_cmd_word_count), 0);
        chk("reset_line", int'(Line_index), 0);
        chk("reset_fs", int'(Frame_start), 0);
        chk("reset_ovr", int'(Line_overrun), 0);
        RST = 1'b0;

        // frame A: nominal frame, Enable held high
        build_table();
        run_frame(1'b0);
        fa = f0;

        // frame B: same-cycle ack on VSS, FIFO not ready on line 2
        build_table();
        j = idx_of(0, 6'h01);
        t = tbl[j]; t.ack_dly = 0; tbl[j] = t;
        j = idx_of(2, 6'h3E) - 1;
        t = tbl[j]; t.hold = 20; tbl[j] = t;
        run_frame(1'b1);
        chk("frame_period", f0 - fa, 240);
        settle();
        chk("idle_b_line", int'(Line_index), 0);
        chk("idle_b_req", int'(Tx_cmd_req), 0);
        chk("idle_b_fs_cnt", fs_cnt, 2);

        // frame C: late payload end forces a line overrun
        Enable = 1'b1;
        build_table();
        j = idx_of(2, 6'h3E);
        t = tbl[j]; t.en_dly = 50; t.chk_ovr = 1'b1; tbl[j] = t;
        j = idx_of(3, 6'h21);
        t = tbl[j]; t.rise = -1; tbl[j] = t;
        run_frame(1'b1);
        settle();
        chk("idle_c_ovr_sticky", int'(Line_overrun), 1);
        chk("idle_c_fs_cnt", fs_cnt, 3);
        chk("idle_c_line", int'(Line_index), 0);

        // frame D: reset during payload, then frame E from a clean start
        Enable = 1'b1;
        build_table();
        j = idx_of(2, 6'h3E);
        t = tbl[j]; t.rst_pay = 1'b1; tbl[j] = t;
        run_frame(1'b0);
        build_table();
        run_frame(1'b1);
        settle();
        chk("idle_e_ovr", int'(Line_overrun), 0);
        chk("idle_e_fs_cnt", fs_cnt, 5);
        chk("idle_e_req", int'(Tx_cmd_req), 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
